// File: rtl/jtpang_objdma.sv
// Object attribute DMA: copies LEN bytes from the CPU-side RAM into the object
// buffer while holding the CPU bus, advancing only on pixel clock enables.
module jtpang_objdma #(
  parameter logic [11:0] SRC_BASE = 12'h000,
  parameter int          LEN      = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        dma_go,
  output logic        busrq,
  input  logic        busak_n,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_dout,
  output logic [10:0] obj_addr,
  output logic [7:0]  obj_din,
  output logic        obj_we,
  output logic        busy
);

  localparam logic [10:0] LAST = 11'(LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        busrq_q, busrq_d;
  logic        busy_q, busy_d;
  logic        pend_q, pend_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic        go_s;
  logic        granted_s;

  assign go_s      = cen & dma_go;
  assign granted_s = cen & ~busak_n;

  // State register and registered handshake/address outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 11'd0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      ram_addr_q <= SRC_BASE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // Next-state logic; losing the bus in READ/WRITE simply freezes everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busrq_d = busrq_q;
    busy_d  = busy_q;
    // A request while busy is remembered once; REL consumes it
    if (go_s && busy_q) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          busrq_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 11'd0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (granted_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_READ: begin
        if (granted_s) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (granted_s) begin
          if (cnt_q == LAST) begin
            cnt_d   = 11'd0;
            busrq_d = pend_q | go_s;
            state_d = ST_REL;
          end else begin
            cnt_d   = cnt_q + 11'd1;
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_REL: begin
        if (cen && (pend_q || dma_go)) begin
          pend_d  = 1'b0;
          busrq_d = 1'b1;
          cnt_d   = 11'd0;
          state_d = ST_REQ;
        end else if (cen && busak_n) begin
          busy_d  = 1'b0;
          busrq_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REL;
        end
      end
      default: begin
        busrq_d = 1'b0;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
        cnt_d   = 11'd0;
        state_d = ST_IDLE;
      end
    endcase
    ram_addr_d = SRC_BASE + {1'b0, cnt_d};
  end

  // The write strobe must be a single clk wide and coincide with cen
  assign obj_we   = rst_n & granted_s & (state_q == ST_WRITE);
  assign obj_din  = (state_q == ST_WRITE) ? ram_dout : 8'h00;
  assign obj_addr = cnt_q;
  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: a write-order scoreboard checks every
// obj_we against the expected byte stream, plus hand-computed spot checks.
module tb_jtpang_objdma;
  localparam logic [11:0] SRC = 12'hF00;
  localparam int          LEN = 512;

  logic        clk = 1'b0;
  logic        rst_n, cen, dma_go, busrq, busak_n, obj_we, busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout, obj_din;
  logic [10:0] obj_addr;
  logic [7:0]  ram [0:4095];

  int tests = 0, fails = 0;
  bit cen_hold = 1'b0, force_hi = 1'b0, stall_active = 1'b0, mon_rq = 1'b0;
  int exp_idx = 0, writes_total = 0, cen_idx = 0, first_cen = -1, last_cen = -1;
  int          wcount    [LEN];
  logic [11:0] addr_seen [LEN];
  logic [7:0]  din_seen  [LEN];

  always #5 clk = ~clk;

  jtpang_objdma #(.SRC_BASE(SRC), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .busrq(busrq),
    .busak_n(busak_n), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .obj_addr(obj_addr), .obj_din(obj_din), .obj_we(obj_we), .busy(busy)
  );

  // Source RAM: offset i from SRC holds i ^ 0x5A, read synchronously on cen
  initial begin
    for (int a = 0; a < 4096; a++) ram[a] = 8'(((a - int'(SRC) + 4096) % 4096) ^ 'h5A);
    ram_dout = 8'h00;
  end
  always @(posedge clk) if (cen) ram_dout <= ram[ram_addr];

  // cen every third clk; CPU grants the bus one clk after busrq
  initial begin
    int ph;
    ph = 0; cen = 1'b0; busak_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      if (!cen_hold) cen = (ph == 0);
      else cen = 1'b0;
      busak_n = force_hi ? 1'b1 : ~busrq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: writes must appear in byte order with the expected data
  always @(negedge clk) begin
    if (cen) cen_idx++;
    if (mon_rq && writes_total < 2 * LEN) chk("busrq_continuous", 32'(busrq), 32'd1);
    if (!cen) chk("we_without_cen", 32'(obj_we), 32'd0);
    if (stall_active) chk("we_during_stall", 32'(obj_we), 32'd0);
    if (obj_we) begin
      chk("obj_addr", 32'(obj_addr), 32'(exp_idx));
      chk("obj_din", 32'(obj_din), 32'((exp_idx ^ 'h5A) & 'hFF));
      chk("ram_addr", 32'(ram_addr), 32'((int'(SRC) + exp_idx) % 4096));
      addr_seen[exp_idx] = ram_addr;
      din_seen[exp_idx]  = obj_din;
      wcount[exp_idx]++;
      if (first_cen < 0) first_cen = cen_idx;
      last_cen = cen_idx;
      writes_total++;
      exp_idx = (exp_idx + 1) % LEN;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic clear_model();
    exp_idx = 0; writes_total = 0; first_cen = -1; last_cen = -1;
    for (int i = 0; i < LEN; i++) wcount[i] = 0;
  endtask

  task automatic pulse_go();
    int n;
    n = 0;
    while (!cen && n < 10) begin step(); n++; end
    dma_go = 1'b1;
    step();
    dma_go = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string name);
    int n;
    n = 0;
    while (writes_total < target && n < 40000) begin step(); n++; end
    chk(name, 32'(writes_total >= target), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin step(); n++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic check_counts(input string name, input int each);
    int bad;
    bad = 0;
    for (int i = 0; i < LEN; i++) if (wcount[i] != each) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [11:0] s_addr;
    logic [10:0] s_oaddr;
    logic        s_rq, s_busy;
    int          s_writes;

    rst_n = 1'b0; dma_go = 1'b0;
    repeat (3) step();
    chk("rst_busrq", 32'(busrq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_obj_we", 32'(obj_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'hF00);
    chk("rst_obj_addr", 32'(obj_addr), 32'd0);
    chk("rst_obj_din", 32'(obj_din), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Basic transfer with address wrap at 0xFFF
    clear_model();
    pulse_go();
    chk("busy_on_accept", 32'(busy), 32'd1);
    chk("busrq_on_accept", 32'(busrq), 32'd1);
    wait_writes(LEN, "basic_timeout");
    wait_idle("basic_busy_fall");
    chk("basic_total", 32'(writes_total), 32'd512);
    check_counts("basic_once", 1);
    chk("wrap_first", 32'(addr_seen[0]), 32'hF00);
    chk("wrap_fff", 32'(addr_seen[255]), 32'hFFF);
    chk("wrap_000", 32'(addr_seen[256]), 32'h000);
    chk("wrap_last", 32'(addr_seen[511]), 32'h0FF);
    chk("din_1", 32'(din_seen[1]), 32'h5B);
    chk("din_511", 32'(din_seen[511]), 32'hA5);
    chk("basic_cen_span", 32'(last_cen - first_cen), 32'd1022);
    repeat (10) step();

    // Bus taken away for 10 cen cycles before byte 100
    clear_model();
    pulse_go();
    wait_writes(100, "stall_reach");
    force_hi = 1'b1; stall_active = 1'b1;
    begin
      int k, n;
      k = 0; n = 0;
      while (k < 10 && n < 200) begin step(); n++; if (cen) k++; end
    end
    chk("stall_no_progress", 32'(writes_total), 32'd100);
    chk("stall_busrq_held", 32'(busrq), 32'd1);
    force_hi = 1'b0; stall_active = 1'b0;
    wait_writes(LEN, "stall_timeout");
    wait_idle("stall_busy_fall");
    chk("stall_total", 32'(writes_total), 32'd512);
    chk("stall_byte100", 32'(wcount[100]), 32'd1);
    check_counts("stall_once", 1);
    repeat (10) step();

    // Second request queued at byte 300, third one ignored
    clear_model();
    pulse_go();
    mon_rq = 1'b1;
    wait_writes(300, "pend_reach");
    pulse_go();
    wait_writes(400, "pend_reach2");
    pulse_go();
    wait_writes(2 * LEN, "pend_timeout");
    mon_rq = 1'b0;
    wait_idle("pend_busy_fall");
    repeat (300) step();
    chk("pend_total", 32'(writes_total), 32'd1024);
    chk("pend_idle_busy", 32'(busy), 32'd0);
    check_counts("pend_twice", 2);

    // Reset at byte 200, with cen low to show it does not depend on cen
    clear_model();
    pulse_go();
    wait_writes(200, "rst_reach");
    cen_hold = 1'b1; cen = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midrst_busrq", 32'(busrq), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_obj_we", 32'(obj_we), 32'd0);
    chk("midrst_ram_addr", 32'(ram_addr), 32'hF00);
    chk("midrst_obj_addr", 32'(obj_addr), 32'd0);
    step();
    rst_n = 1'b1; cen_hold = 1'b0;
    repeat (5) step();
    clear_model();
    pulse_go();
    wait_writes(LEN, "restart_timeout");
    wait_idle("restart_busy_fall");
    check_counts("restart_once", 1);
    chk("restart_first_addr", 32'(addr_seen[0]), 32'hF00);
    repeat (10) step();

    // cen held low for 50 clk mid-transfer
    clear_model();
    pulse_go();
    wait_writes(250, "gate_reach");
    cen_hold = 1'b1; cen = 1'b0;
    s_addr = ram_addr; s_oaddr = obj_addr; s_rq = busrq; s_busy = busy;
    s_writes = writes_total;
    repeat (50) step();
    chk("gate_writes", 32'(writes_total), 32'(s_writes));
    chk("gate_ram_addr", 32'(ram_addr), 32'(s_addr));
    chk("gate_obj_addr", 32'(obj_addr), 32'(s_oaddr));
    chk("gate_busrq", 32'(busrq), 32'(s_rq));
    chk("gate_busy", 32'(busy), 32'(s_busy));
    cen_hold = 1'b0;
    wait_writes(LEN, "gate_timeout");
    wait_idle("gate_busy_fall");
    check_counts("gate_once", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtpang_objdma.md
JTPANG_OBJDMA -- requirements
Module: jtpang_objdma

Interface
REQ-001 Parameter SRC_BASE, 12'h000: source start address in the CPU-side object attribute RAM.
REQ-002 Parameter LEN, 512: number of bytes copied per transfer; a power of two from 4 to 2048.
REQ-003 The clock is clk; reset is synchronous and active-low (rst_n).
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 cen  in  1  pixel clock enable (6 MHz); all state advances only on cycles where cen=1.
REQ-007 dma_go  in  1  transfer request, one cen-qualified pulse from the main CPU decoder.
REQ-008 busrq  out  1  bus request to the CPU, active high.
REQ-009 busak_n  in  1  CPU bus acknowledge, active low.
REQ-010 ram_addr  out  12  source RAM read address.
REQ-011 ram_dout  in  8  source RAM read data, valid on the cen after the address is driven.
REQ-012 obj_addr  out  11  destination object buffer address.
REQ-013 obj_din  out  8  destination write data.
REQ-014 obj_we  out  1  destination write strobe, high for exactly one clk cycle per byte.
REQ-015 busy  out  1  high from the dma_go acceptance to the return to IDLE.

Function
REQ-016 States: IDLE, REQ, READ, WRITE, REL.
REQ-017 IDLE: when dma_go=1 and cen=1, the block sets busrq=1, clears cnt to 0 and moves to REQ.
REQ-018 REQ: the block holds busrq=1 and moves to READ on the first cen with busak_n=0.
REQ-019 READ: ram_addr=SRC_BASE+cnt (12-bit wrap); the block moves to WRITE on the next cen.
REQ-020 WRITE: on a cen cycle the block asserts obj_we=1 for that single clk cycle, with obj_addr=cnt and obj_din=ram_dout.
REQ-021 WRITE, after the write: cnt increments; if cnt was LEN-1 the block moves to REL, otherwise it returns to READ.
REQ-022 Per-byte cost is 2 cen cycles; a full transfer is 2*LEN cen cycles plus the handshake.
REQ-023 REL: the block drops busrq, and returns to IDLE on the first cen with busak_n=1.
REQ-024 If busak_n goes high during READ or WRITE, the block stalls: no obj_we, cnt and state held, busrq kept at 1, and it resumes at the same byte once busak_n=0.
REQ-025 A dma_go arriving while busy=1 sets a pending flag, and further pulses do not accumulate.
REQ-026 In REL, if the pending flag is set, the block clears it, keeps busrq=1, zeroes cnt and goes to REQ without passing through IDLE.
REQ-027 obj_we=0 whenever cen=0 and in every state other than WRITE.
REQ-028 cnt is 11 bits wide; obj_addr never exceeds LEN-1.
REQ-029 The source address wraps modulo 4096.

Reset
REQ-030 While rst_n=0, on any clk edge regardless of cen, the block sets: state=IDLE, busrq=0, busy=0, obj_we=0, cnt=0, pending=0, ram_addr=SRC_BASE, obj_addr=0, obj_din=0.
REQ-031 A reset mid-transfer aborts it at once: busrq=0 on the next clk edge, and the partially written buffer is left as is.

Verification
REQ-032 Basic transfer: with busak_n tied to busrq inverted, one cycle later, and ram[i]=i^8'h5A, a dma_go pulse produces 512 obj_we pulses with obj_addr 0..511 and obj_din=i^8'h5A; busy then falls.
REQ-033 Stall: busak_n is forced high for 10 cen cycles at byte 100. There is no obj_we during the stall, byte 100 is written exactly once, and the transfer still ends with 512 writes in total.
REQ-034 Pending request: a second dma_go at byte 300 gives busrq continuously high, two full transfers and 1024 writes; a third pulse during the same transfer adds nothing.
REQ-035 Mid-transfer reset: rst_n is pulled low at byte 200. On the next clk edge busrq=0, busy=0 and obj_we=0, and a later dma_go restarts cleanly from obj_addr 0.
REQ-036 Wrap-around: with SRC_BASE=12'hF00 and LEN=512, ram_addr runs 0xF00..0xFFF then 0x000..0x0FF.
REQ-037 Cen gating: with cen held low for 50 clk cycles mid-transfer, there are no state changes and no obj_we pulses.
